// File: rtl/niosvprocessor_sram_bist_pkg.sv
// Shared types and constants for the SRAM built-in self test engine.
package niosvprocessor_sram_bist_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CHECK,
      ST_WRITE,
      ST_READ,
      ST_DRAIN,
      ST_DONE
   } state_t;

   localparam logic [1:0] MODE_ADDR    = 2'd0;
   localparam logic [1:0] MODE_LFSR    = 2'd1;
   localparam logic [1:0] MODE_CHECKER = 2'd2;
   localparam logic [1:0] MODE_CONST   = 2'd3;

   localparam logic [31:0] LFSR_TAPS = 32'h80200003;
   localparam int          ERR_CNT_W = 16;

endpackage

// File: rtl/niosvprocessor_sram_bist_if.sv
// Avalon-MM port between the BIST initiator and the SRAM's second slave port.
interface niosvprocessor_sram_bist_if #(
   parameter int ADDR_W = 17,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0]   address;
   logic [DATA_W/8-1:0] byteenable;
   logic                chipselect;
   logic                write;
   logic [DATA_W-1:0]   writedata;
   logic [DATA_W-1:0]   readdata;

   modport master (
      output address, byteenable, chipselect, write, writedata,
      input  readdata
   );

   modport slave (
      input  address, byteenable, chipselect, write, writedata,
      output readdata
   );
endinterface

// File: rtl/niosvprocessor_sram_bist_patgen.sv
// Test pattern generator; reloaded from the seed before the write and read passes
// so both passes produce the identical word sequence.
module niosvprocessor_sram_bist_patgen
   import niosvprocessor_sram_bist_pkg::*;
#(
   parameter int ADDR_W = 17,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        mode,
   input  logic [DATA_W-1:0] seed,
   input  logic [ADDR_W-1:0] address,
   input  logic              load,
   input  logic              advance,
   output logic [DATA_W-1:0] word
);

   localparam logic [DATA_W-1:0] TAPS     = DATA_W'(LFSR_TAPS);
   localparam logic [DATA_W-1:0] LFSR_ONE = {{(DATA_W-1){1'b0}}, 1'b1};

   logic [DATA_W-1:0] lfsr_q;

   // Galois LFSR state; an all-zero seed would lock up, so it is replaced by 1.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lfsr_q <= '0;
      end else if (load) begin
         lfsr_q <= (seed == '0) ? LFSR_ONE : seed;
      end else if (advance) begin
         lfsr_q <= (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
      end
   end

   // Current pattern word for the access being issued.
   always_comb begin
      word = seed;
      unique case (mode)
         MODE_ADDR:    word = seed ^ DATA_W'(address);
         MODE_LFSR:    word = lfsr_q;
         MODE_CHECKER: word = address[0] ? ~seed : seed;
         MODE_CONST:   word = seed;
         default:      word = seed;
      endcase
   end

endmodule

// File: rtl/niosvprocessor_sram_bist.sv
// SRAM BIST: fills [base, base+count) with a pattern, reads it back, and records mismatches.
module niosvprocessor_sram_bist
   import niosvprocessor_sram_bist_pkg::*;
#(
   parameter int ADDR_W = 17,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 125000,
   parameter int RD_LAT = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 abort,
   input  logic [ADDR_W-1:0]    base,
   input  logic [ADDR_W:0]      count,
   input  logic [1:0]           mode,
   input  logic [DATA_W-1:0]    seed,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic                 range_err,
   output logic [ADDR_W-1:0]    err_addr,
   output logic [DATA_W-1:0]    err_data,
   output logic [ERR_CNT_W-1:0] err_count,
   niosvprocessor_sram_bist_if.master avm
);

   localparam logic [ADDR_W+1:0]    DEPTH_V    = (ADDR_W+2)'(DEPTH);
   localparam logic [ADDR_W:0]      IDX_ONE    = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0]    ADDR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ERR_CNT_W-1:0] ERR_ONE    = {{(ERR_CNT_W-1){1'b0}}, 1'b1};
   localparam logic [2:0]           DRAIN_LAST = 3'(RD_LAT - 1);

   state_t state, state_next;

   logic [ADDR_W-1:0] base_q, addr_q;
   logic [ADDR_W:0]   count_q, idx_q;
   logic [1:0]        mode_q;
   logic [DATA_W-1:0] seed_q, pat_word;
   logic [2:0]        drain_q;
   logic              cs, wr;

   logic              pipe_valid [RD_LAT];
   logic [ADDR_W-1:0] pipe_addr  [RD_LAT];
   logic [DATA_W-1:0] pipe_exp   [RD_LAT];

   logic              start_ok, abort_now, last_word, range_bad, mismatch;
   logic [ADDR_W+1:0] range_sum;

   assign busy      = (state == ST_CHECK) || (state == ST_WRITE) ||
                      (state == ST_READ)  || (state == ST_DRAIN);
   assign start_ok  = start && !abort && ((state == ST_IDLE) || (state == ST_DONE));
   assign abort_now = abort && busy;
   assign last_word = (idx_q == IDX_ONE);
   assign range_sum = {2'b00, base_q} + {1'b0, count_q};
   assign range_bad = (range_sum > DEPTH_V);
   assign mismatch  = pipe_valid[RD_LAT-1] && !abort_now &&
                      (avm.readdata != pipe_exp[RD_LAT-1]);

   niosvprocessor_sram_bist_patgen #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_patgen (
      .clk     (clk),
      .reset   (reset),
      .mode    (mode_q),
      .seed    (seed_q),
      .address (addr_q),
      .load    ((state == ST_CHECK) || ((state == ST_WRITE) && last_word)),
      .advance (((state == ST_WRITE) && !last_word) || (state == ST_READ)),
      .word    (pat_word)
   );

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic; abort from any busy state overrides everything.
   always_comb begin
      state_next = state;
      unique case (state)
         ST_IDLE, ST_DONE: if (start_ok) state_next = ST_CHECK;
         ST_CHECK: begin
            if (range_bad)             state_next = ST_DONE;
            else if (count_q == '0)    state_next = ST_DONE;
            else                       state_next = ST_WRITE;
         end
         ST_WRITE: if (last_word)             state_next = ST_READ;
         ST_READ:  if (last_word)             state_next = ST_DRAIN;
         ST_DRAIN: if (drain_q == DRAIN_LAST) state_next = ST_DONE;
         default:                             state_next = ST_IDLE;
      endcase
      if (abort_now) state_next = ST_IDLE;
   end

   // Bus strobes and status decoded from the state.
   always_comb begin
      cs   = 1'b0;
      wr   = 1'b0;
      done = 1'b0;
      unique case (state)
         ST_WRITE: begin
            cs = 1'b1;
            wr = 1'b1;
         end
         ST_READ: cs   = 1'b1;
         ST_DONE: done = 1'b1;
         default: ;
      endcase
   end

   assign avm.chipselect = cs;
   assign avm.write      = wr;
   assign avm.byteenable = {(DATA_W/8){cs}};
   assign avm.address    = cs ? addr_q : '0;
   assign avm.writedata  = wr ? pat_word : '0;
   assign pass           = done && (err_count == '0) && !range_err;

   // Operand capture, address walk, drain timer and mismatch bookkeeping.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         base_q    <= '0;
         count_q   <= '0;
         mode_q    <= '0;
         seed_q    <= '0;
         addr_q    <= '0;
         idx_q     <= '0;
         drain_q   <= '0;
         range_err <= 1'b0;
         err_addr  <= '0;
         err_data  <= '0;
         err_count <= '0;
      end else begin
         if (start_ok) begin
            base_q    <= base;
            count_q   <= count;
            mode_q    <= mode;
            seed_q    <= seed;
            addr_q    <= base;
            range_err <= 1'b0;
            err_addr  <= '0;
            err_data  <= '0;
            err_count <= '0;
         end
         drain_q <= '0;
         unique case (state)
            ST_CHECK: begin
               idx_q <= count_q;
               if (range_bad) range_err <= 1'b1;
            end
            ST_WRITE: begin
               addr_q <= last_word ? base_q : addr_q + ADDR_ONE;
               idx_q  <= last_word ? count_q : idx_q - IDX_ONE;
            end
            ST_READ: begin
               addr_q <= addr_q + ADDR_ONE;
               idx_q  <= idx_q - IDX_ONE;
            end
            ST_DRAIN: drain_q <= drain_q + 3'd1;
            default: ;
         endcase
         if (mismatch) begin
            if (err_count != '1) err_count <= err_count + ERR_ONE;
            if (err_count == '0) begin
               err_addr <= pipe_addr[RD_LAT-1];
               err_data <= avm.readdata;
            end
         end
      end
   end

   // Read pipeline carrying address and expected word until readdata is valid.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < RD_LAT; i++) begin
            pipe_valid[i] <= 1'b0;
            pipe_addr[i]  <= '0;
            pipe_exp[i]   <= '0;
         end
      end else if (abort_now) begin
         for (int i = 0; i < RD_LAT; i++) pipe_valid[i] <= 1'b0;
      end else begin
         pipe_valid[0] <= (state == ST_READ);
         pipe_addr[0]  <= addr_q;
         pipe_exp[0]   <= pat_word;
         for (int i = 1; i < RD_LAT; i++) begin
            pipe_valid[i] <= pipe_valid[i-1];
            pipe_addr[i]  <= pipe_addr[i-1];
            pipe_exp[i]   <= pipe_exp[i-1];
         end
      end
   end

endmodule

// File: tb/tb_niosvprocessor_sram_bist.sv
// Scoreboard bench for the SRAM BIST with a behavioural RD_LAT=1 SRAM model.
module tb_niosvprocessor_sram_bist;
   import niosvprocessor_sram_bist_pkg::*;

   localparam int ADDR_W = 17;
   localparam int DATA_W = 32;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic              abort = 1'b0;
   logic [ADDR_W-1:0] base = '0;
   logic [ADDR_W:0]   count = '0;
   logic [1:0]        mode = '0;
   logic [DATA_W-1:0] seed = '0;
   logic              busy, done, pass, range_err;
   logic [ADDR_W-1:0] err_addr;
   logic [DATA_W-1:0] err_data;
   logic [15:0]       err_count;

   niosvprocessor_sram_bist_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) avm_bus ();

   niosvprocessor_sram_bist #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(125000), .RD_LAT(1)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .base(base), .count(count), .mode(mode), .seed(seed),
      .busy(busy), .done(done), .pass(pass), .range_err(range_err),
      .err_addr(err_addr), .err_data(err_data), .err_count(err_count),
      .avm(avm_bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        pass_v;
      logic        range_v;
      logic [15:0] cnt;
      logic [16:0] eaddr;
      logic [31:0] edata;
      int          lat;
      int          cs;
   } result_t;

   typedef struct {
      logic [16:0] addr;
      logic [31:0] data;
   } wr_t;

   result_t res_q[$];
   wr_t     wr_q[$];
   result_t r;
   wr_t     w;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int start_cyc = 0;
   int cs_total = 0;
   int cs_at_start = 0;
   bit skip_wr = 1'b0;
   bit fault_on = 1'b0;
   logic done_prev = 1'b0;

   logic [31:0] mem [0:(1<<ADDR_W)-1];
   logic [31:0] lfsr_tab [8];

   // SRAM model: one-cycle read latency, optional bit-5 stuck-at-1 at word 0x0A.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (avm_bus.chipselect && avm_bus.write)
         mem[avm_bus.address] <= avm_bus.writedata;
      if (avm_bus.chipselect && !avm_bus.write)
         avm_bus.readdata <= mem[avm_bus.address] |
            ((fault_on && avm_bus.address == 17'h0A) ? 32'h20 : 32'h0);
   end

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic push_result(input logic p, input logic re, input logic [15:0] c,
                              input logic [16:0] ea, input logic [31:0] ed, input int lat, input int cs);
      result_t x;
      x.pass_v = p; x.range_v = re; x.cnt = c; x.eaddr = ea; x.edata = ed; x.lat = lat; x.cs = cs;
      res_q.push_back(x);
   endtask

   task automatic push_write(input logic [16:0] a, input logic [31:0] d);
      wr_t x;
      x.addr = a; x.data = d;
      wr_q.push_back(x);
   endtask

   task automatic apply_stimulus(input logic [16:0] b, input logic [17:0] n,
                                 input logic [1:0] m, input logic [31:0] s);
      @(negedge clk);
      base = b; count = n; mode = m; seed = s; start = 1'b1;
      start_cyc = cyc; cs_at_start = cs_total;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (!done && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (!done) begin
         checks++; errors++;
         $display("[TB] FAIL %s_timeout actual=done0 required=done1", name);
      end
      @(negedge clk);
   endtask

   // Monitor: checks every write against the expected queue and every done rise against the result queue.
   always @(negedge clk) begin
      if (avm_bus.chipselect) cs_total++;
      if (avm_bus.chipselect && avm_bus.write && !skip_wr) begin
         if (wr_q.size() == 0) begin
            checks++; errors++;
            $display("[TB] FAIL unexpected_write actual=%0h required=none", avm_bus.address);
         end else begin
            w = wr_q.pop_front();
            check_output("wr_addr", 64'(avm_bus.address), 64'(w.addr));
            check_output("wr_data", 64'(avm_bus.writedata), 64'(w.data));
            check_output("wr_be", 64'(avm_bus.byteenable), 64'hF);
         end
      end
      if (done && !done_prev) begin
         if (res_q.size() == 0) begin
            checks++; errors++;
            $display("[TB] FAIL unexpected_done actual=1 required=0");
         end else begin
            r = res_q.pop_front();
            check_output("pass", 64'(pass), 64'(r.pass_v));
            check_output("range_err", 64'(range_err), 64'(r.range_v));
            check_output("err_count", 64'(err_count), 64'(r.cnt));
            check_output("err_addr", 64'(err_addr), 64'(r.eaddr));
            check_output("err_data", 64'(err_data), 64'(r.edata));
            check_output("latency", 64'(cyc - start_cyc), 64'(r.lat));
            check_output("bus_cycles", 64'(cs_total - cs_at_start), 64'(r.cs));
            check_output("busy_at_done", 64'(busy), 64'h0);
         end
      end
      done_prev = done;
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog actual=running required=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int rd;
      int n;
      lfsr_tab[0] = 32'h00000001; lfsr_tab[1] = 32'h80200003;
      lfsr_tab[2] = 32'hC0300002; lfsr_tab[3] = 32'h60180001;
      lfsr_tab[4] = 32'hB02C0003; lfsr_tab[5] = 32'hD8360002;
      lfsr_tab[6] = 32'h6C1B0001; lfsr_tab[7] = 32'hB62D8003;

      // Reset state.
      repeat (2) @(negedge clk);
      check_output("rst_busy", 64'(busy), 64'h0);
      check_output("rst_done", 64'(done), 64'h0);
      check_output("rst_pass", 64'(pass), 64'h0);
      check_output("rst_cs", 64'(avm_bus.chipselect), 64'h0);
      check_output("rst_be", 64'(avm_bus.byteenable), 64'h0);
      check_output("rst_err_count", 64'(err_count), 64'h0);
      reset = 1'b0;
      @(negedge clk);

      // Address pattern, 16 words.
      for (int i = 0; i < 16; i++) push_write(17'(i), 32'(i));
      push_result(1'b1, 1'b0, 16'd0, 17'd0, 32'd0, 35, 32);
      apply_stimulus(17'd0, 18'd16, MODE_ADDR, 32'd0);
      wait_done("addr16");

      // Stuck bit at word 0x0A with constant zero pattern.
      fault_on = 1'b1;
      for (int i = 0; i < 32; i++) push_write(17'(i), 32'd0);
      push_result(1'b0, 1'b0, 16'd1, 17'h0A, 32'h20, 67, 64);
      apply_stimulus(17'd0, 18'd32, MODE_CONST, 32'd0);
      wait_done("fault");
      fault_on = 1'b0;

      // One word past the end: range error, no bus activity.
      push_result(1'b0, 1'b1, 16'd0, 17'd0, 32'd0, 2, 0);
      apply_stimulus(17'd124990, 18'd11, MODE_ADDR, 32'd0);
      wait_done("range_over");

      // Exactly up to the top address.
      for (int i = 0; i < 10; i++) push_write(17'(124990 + i), 32'(124990 + i));
      push_result(1'b1, 1'b0, 16'd0, 17'd0, 32'd0, 23, 20);
      apply_stimulus(17'd124990, 18'd10, MODE_ADDR, 32'd0);
      wait_done("range_top");

      // Zero words.
      push_result(1'b1, 1'b0, 16'd0, 17'd0, 32'd0, 2, 0);
      apply_stimulus(17'd7, 18'd0, MODE_CHECKER, 32'h55);
      wait_done("count0");

      // LFSR with zero seed.
      for (int i = 0; i < 8; i++) push_write(17'(i), lfsr_tab[i]);
      push_result(1'b1, 1'b0, 16'd0, 17'd0, 32'd0, 19, 16);
      apply_stimulus(17'd0, 18'd8, MODE_LFSR, 32'd0);
      wait_done("lfsr");

      // Abort during read of word 5; a start pulse while busy must be ignored.
      for (int i = 0; i < 20; i++) push_write(17'(100 + i), 32'h12345678 ^ 32'(100 + i));
      apply_stimulus(17'd100, 18'd20, MODE_ADDR, 32'h12345678);
      base = 17'd0; count = 18'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      rd = 0;
      n = 0;
      while (n < 500) begin
         @(negedge clk);
         n++;
         if (avm_bus.chipselect && !avm_bus.write) begin
            if (rd == 5) break;
            rd++;
         end
      end
      check_output("abort_reached_read5", 64'(rd), 64'd5);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check_output("abort_cs", 64'(avm_bus.chipselect), 64'h0);
      check_output("abort_busy", 64'(busy), 64'h0);
      check_output("abort_done", 64'(done), 64'h0);
      check_output("abort_err_count", 64'(err_count), 64'h0);

      // Restart after abort, checkerboard.
      push_write(17'd200, 32'h0F0F0F0F);
      push_write(17'd201, 32'hF0F0F0F0);
      push_write(17'd202, 32'h0F0F0F0F);
      push_write(17'd203, 32'hF0F0F0F0);
      push_result(1'b1, 1'b0, 16'd0, 17'd0, 32'd0, 11, 8);
      apply_stimulus(17'd200, 18'd4, MODE_CHECKER, 32'h0F0F0F0F);
      wait_done("after_abort");

      // Asynchronous reset in the middle of the write pass.
      skip_wr = 1'b1;
      apply_stimulus(17'd0, 18'd20, MODE_ADDR, 32'hAAAA5555);
      repeat (6) @(negedge clk);
      check_output("pre_reset_write", 64'(avm_bus.write), 64'h1);
      #2 reset = 1'b1;
      #1;
      check_output("arst_busy", 64'(busy), 64'h0);
      check_output("arst_cs", 64'(avm_bus.chipselect), 64'h0);
      check_output("arst_write", 64'(avm_bus.write), 64'h0);
      check_output("arst_be", 64'(avm_bus.byteenable), 64'h0);
      check_output("arst_addr", 64'(avm_bus.address), 64'h0);
      check_output("arst_wdata", 64'(avm_bus.writedata), 64'h0);
      check_output("arst_done", 64'(done), 64'h0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_output("post_rst_busy", 64'(busy), 64'h0);
      check_output("post_rst_cs", 64'(avm_bus.chipselect), 64'h0);
      skip_wr = 1'b0;

      // Normal run from IDLE after reset.
      push_write(17'd5, 32'hDEADBEEF);
      push_write(17'd6, 32'hDEADBEEF);
      push_result(1'b1, 1'b0, 16'd0, 17'd0, 32'd0, 7, 4);
      apply_stimulus(17'd5, 18'd2, MODE_CONST, 32'hDEADBEEF);
      wait_done("post_reset_run");

      repeat (2) @(negedge clk);
      check_output("results_left", 64'(res_q.size()), 64'd0);
      check_output("writes_left", 64'(wr_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/niosvprocessor_sram_bist.md
Name: niosvprocessor_sram_bist

Overview:
- Avalon-MM initiator that drives the on-chip SRAM slave port (address/byteenable/chipselect/write/writedata → readdata) to fill and verify a word range.
- Writes a selectable pattern over [base, base+count), reads it back and compares. Captures the first mismatch and counts all mismatches.
- Sits between a CSR/debug controller and the SRAM's second slave port. Used for power-on memory test and scrubbing.

Parameters:
- ADDR_W, 17, word-address width of the SRAM port.
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- DEPTH, 125000, number of valid words; the range check uses this value.
- RD_LAT, 1, fixed read latency in clk cycles from read issue to valid readdata (1..4).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; accepted only in IDLE.
- abort  in  1  level; stops the test and returns to IDLE.
- base  in  ADDR_W  first word address, sampled on start.
- count  in  ADDR_W+1  number of words, sampled on start.
- mode  in  2  pattern: 0 address, 1 LFSR, 2 checkerboard, 3 constant seed.
- seed  in  DATA_W  pattern seed, sampled on start.
- busy  out  1  high from accepted start until DONE or IDLE.
- done  out  1  high in DONE; cleared by the next accepted start.
- pass  out  1  done and err_count==0 and not range_err.
- range_err  out  1  base+count > DEPTH; set at start.
- err_addr  out  ADDR_W  address of the first mismatch.
- err_data  out  DATA_W  readdata of the first mismatch.
- err_count  out  16  mismatch count, saturates at 16'hFFFF.
- avm_address  out  ADDR_W  SRAM address.
- avm_byteenable  out  DATA_W/8  always all-ones when chipselect is high.
- avm_chipselect  out  1  access strobe.
- avm_write  out  1  write qualifier.
- avm_writedata  out  DATA_W  write data.
- avm_readdata  in  DATA_W  SRAM read data.

Behaviour:
- Reset (asynchronous, active-high) clears every output and all state. The outputs return to 0; avm_byteenable returns to 0.
- FSM states: IDLE, CHECK, WRITE, READ, DRAIN, DONE.
- IDLE: on start, latch base/count/mode/seed, clear err_* and done, set busy, go to CHECK.
- CHECK (1 cycle): compute base+count in ADDR_W+2 bits, unsigned.
  - If the sum > DEPTH: set range_err and go to DONE with no bus access.
  - If count==0: go to DONE.
  - Otherwise go to WRITE.
- WRITE: one write per cycle (chipselect=1, write=1). Address increments from base. The slave has no waitrequest.
  - After the last word, reset the pattern generator to seed and go to READ.
- READ: one read per cycle (chipselect=1, write=0), addresses base..base+count-1.
  - Push {valid, address, expected} into an RD_LAT-deep shift pipeline.
  - After the last issue, go to DRAIN.
- Compare: when the pipeline tail is valid, compare avm_readdata against expected.
  - On mismatch, increment err_count (saturating).
  - On the first mismatch, latch err_addr and err_data.
- DRAIN: wait RD_LAT cycles until the pipeline is empty, then go to DONE.
- DONE: busy=0, done=1, pass valid. A new start is accepted directly from DONE, with the same actions as from IDLE.
- Patterns (one value per word, advanced on each access):
  - mode 0: data = seed XOR zero-extended address.
  - mode 1: 32-bit Galois LFSR, taps 0x80200003, state initialised to seed. A zero seed is replaced by 0x1.
  - mode 2: seed on even addresses, ~seed on odd addresses.
  - mode 3: seed.
- abort in any busy state:
  - Next cycle: chipselect=0, FSM in IDLE, busy=0, done=0.
  - In-flight read results are discarded; err_* keep their values.
- start while busy: ignored. start and abort in the same IDLE cycle: abort wins, start is dropped.
- Address never wraps, because the range check guarantees base+count ≤ DEPTH. The top address is DEPTH-1.
- Total latency for N>0 words: 1 (CHECK) + N (WRITE) + N (READ) + RD_LAT (DRAIN), then done rises on the next edge.

Decomposition:
- Package niosvprocessor_sram_bist_pkg holds:
  - the state enum;
  - MODE_* constants;
  - LFSR_TAPS = 32'h80200003;
  - ERR_CNT_W = 16.
- Sub-module niosvprocessor_sram_bist_patgen generates the pattern:
  - inputs: mode, seed, address, load, advance;
  - output: word;
  - one instance serves both phases and is reloaded between them.

Test Plan:
- Model: SRAM behavioural model with RD_LAT=1.
  - start base=0, count=16, mode=0, seed=0 → 16 writes with data=address, 16 reads.
  - done after 1+16+16+1 cycles; pass=1; err_count=0.
- Fault injection: model forces bit 5 stuck-at-1 at word 0x0A, base=0, count=32, mode=3, seed=0.
  - err_count=1, err_addr=0x0A, err_data=0x20, pass=0.
- base=124990, count=11 → range_err=1, done=1, pass=0, chipselect never asserted.
- base=124990, count=10 → pass=1; last address 124999.
- count=0 → done two cycles after start, pass=1, no bus activity.
- mode=1, seed=0, count=8 → LFSR seeded with 0x1, readback matches, pass=1.
- abort during READ at word 5 of 20 → chipselect=0 next cycle, busy=0, done=0.
  - A subsequent start with count=4 completes with pass=1.
- Reset asserted mid-WRITE → all outputs 0 asynchronously; FSM in IDLE after reset release.
